// File: rtl/icache.sv
// rtl/icache.sv - direct-mapped instruction cache, 4-word lines, word-serial refill
//
// Ports:
//   clk, rst                 clock; synchronous active-low reset
//   read_flag, addr          fetch request and byte address (addr[1:0] ignored)
//   read_data, busy, done    fetched word (valid with done), in-progress flag, response strobe
//   flush                    invalidate all lines (deferred to IDLE if a request is in flight)
//   mem_read, mem_addr       refill word request and word-aligned address
//   mem_rdata, mem_ready     refill data and completion handshake
module icache #(
    parameter int SETS       = 64,
    parameter int LINE_WORDS = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        read_flag,
    input  logic [31:0] addr,
    output logic [31:0] read_data,
    output logic        busy,
    output logic        done,
    input  logic        flush,
    output logic        mem_read,
    output logic [31:0] mem_addr,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready
);

    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = 28 - IDX_W;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOOKUP,
        S_REFILL,
        S_RESP
    } state_t;

    state_t state;
    state_t state_nx;

    logic [31:2]      req_addr;
    logic [1:0]       cnt;
    logic [SETS-1:0]  valid;
    logic             flush_pend;

    logic [TAG_W-1:0] tag_arr  [SETS];
    logic [31:0]      data_arr [SETS][LINE_WORDS];

    logic [1:0]       req_off;
    logic [IDX_W-1:0] req_idx;
    logic [TAG_W-1:0] req_tag;
    logic             hit;
    logic             last_word;

    // byte-offset bits are never used; the name keeps lint quiet about them
    logic             unused_addr_bits;
    assign unused_addr_bits = ^addr[1:0];

    assign req_off   = req_addr[3:2];
    assign req_idx   = req_addr[4 +: IDX_W];
    assign req_tag   = req_addr[31 -: TAG_W];
    assign hit       = valid[req_idx] && (tag_arr[req_idx] == req_tag);
    assign last_word = mem_ready && (cnt == 2'd3);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= S_IDLE;
            valid      <= '0;
            flush_pend <= 1'b0;
            cnt        <= 2'd0;
            req_addr   <= '0;
        end else begin
            state <= state_nx;
            case (state)
                S_IDLE: begin
                    // a same-edge read looks up the already-cleared array
                    if (flush) begin
                        valid <= '0;
                    end
                    if (read_flag) begin
                        req_addr <= addr[31:2];
                    end
                end
                S_LOOKUP: begin
                    cnt <= 2'd0;
                    if (flush) begin
                        flush_pend <= 1'b1;
                    end
                end
                S_REFILL: begin
                    if (flush) begin
                        flush_pend <= 1'b1;
                    end
                    if (mem_ready) begin
                        cnt <= cnt + 2'd1;
                        if (cnt == 2'd3) begin
                            valid[req_idx] <= 1'b1;
                        end
                    end
                end
                S_RESP: begin
                    // leaving RESP is the entry to IDLE: apply any deferred flush now
                    if (flush || flush_pend) begin
                        valid <= '0;
                    end
                    flush_pend <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    // data and tag storage carries no reset; validity alone qualifies a line
    always_ff @(posedge clk) begin
        if (rst && (state == S_REFILL) && mem_ready) begin
            data_arr[req_idx][cnt] <= mem_rdata;
            if (cnt == 2'd3) begin
                tag_arr[req_idx] <= req_tag;
            end
        end
    end

    always_comb begin
        state_nx  = state;
        busy      = 1'b0;
        done      = 1'b0;
        mem_read  = 1'b0;
        mem_addr  = 32'd0;
        read_data = 32'd0;
        case (state)
            S_IDLE: begin
                if (read_flag) begin
                    state_nx = S_LOOKUP;
                end
            end
            S_LOOKUP: begin
                busy     = 1'b1;
                state_nx = hit ? S_RESP : S_REFILL;
            end
            S_REFILL: begin
                busy     = 1'b1;
                mem_read = 1'b1;
                mem_addr = {req_addr[31:4], cnt, 2'b00};
                if (last_word) begin
                    state_nx = S_RESP;
                end
            end
            S_RESP: begin
                done      = 1'b1;
                read_data = data_arr[req_idx][req_off];
                state_nx  = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

endmodule

// File: doc/icache.md
ICACHE -- requirements
Module: icache

Interface
REQ-001 Parameter SETS, 64, number of direct-mapped lines (power of two, 2..256).
REQ-002 Parameter LINE_WORDS, 4, 32-bit words per line (fixed at 4).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-low reset; sampled on the clk rising edge.
REQ-005 read_flag  input  1  fetch request from the fetch stage.
REQ-006 addr  input  32  fetch byte address; bits [1:0] ignored.
REQ-007 read_data  output  32  fetched instruction; valid only while done=1.
REQ-008 busy  output  1  request in progress; fetch stage holds PC.
REQ-009 done  output  1  one-cycle response strobe.
REQ-010 flush  input  1  invalidate all lines (fence.i).
REQ-011 mem_read  output  1  refill word request to memory.
REQ-012 mem_addr  output  32  refill word address, word-aligned.
REQ-013 mem_rdata  input  32  memory read data.
REQ-014 mem_ready  input  1  mem_rdata valid; completes current mem_read.

Function
REQ-015 Address split: offset = addr[3:2], index = addr[3+log2(SETS):4], tag = remaining upper bits.
REQ-016 Storage: per line a valid bit, tag and 4 data words, all registers.
REQ-017 FSM states: IDLE, LOOKUP, REFILL, RESP.
REQ-018 IDLE: busy=0, done=0; read_flag=1 at an edge latches addr and enters LOOKUP; read_flag=0 stays IDLE.
REQ-019 LOOKUP: busy=1; hit (valid and tag match) -> RESP next edge; miss -> REFILL next edge with word counter=0.
REQ-020 REFILL: busy=1, mem_read=1, mem_addr = {tag, index, counter, 2'b00}; mem_addr and mem_read held stable until mem_ready=1.
REQ-021 REFILL: each edge with mem_ready=1 writes mem_rdata to word[counter] and increments counter; after word 3, tag written, valid set, next state RESP.
REQ-022 mem_read deasserts in the cycle after the last mem_ready; mem_ready while not in REFILL is ignored.
REQ-023 RESP: done=1, busy=0, read_data = line word[offset] of latched address; lasts exactly one cycle; next state IDLE; read_flag ignored in RESP.
REQ-024 Latency from accepting edge: hit -> done in 2nd following cycle; miss -> done 1 cycle after the 4th mem_ready edge.
REQ-025 done and busy never both 1; done never asserted outside RESP.
REQ-026 read_data = 0 whenever done=0.
REQ-027 flush in IDLE: all valid bits cleared at that edge; a read_flag on the same edge is accepted and looks up the cleared array (miss).
REQ-028 flush in LOOKUP/REFILL/RESP: recorded as pending; the in-flight request completes with its refilled data; valid bits cleared on entry to IDLE, before any new lookup.
REQ-029 addr changes while busy are ignored; only the latched address is used.

Reset
REQ-030 rst=0 at an edge: state IDLE, all valid bits 0, pending flush 0, counter 0.
REQ-031 Outputs under reset: busy=0, done=0, read_data=0, mem_read=0, mem_addr=0.
REQ-032 Reset mid-REFILL abandons the refill; partial line stays invalid; memory responses after reset are ignored.
REQ-033 Data and tag arrays need no reset.

Verification
REQ-034 Cold miss: reset, read_flag=1 addr=0x00000104, memory returns 0xA0,0xA1,0xA2,0xA3 for 0x100..0x10C, mem_ready one cycle after each mem_read -> mem_addr sequence 0x100,0x104,0x108,0x10C; done=1 with read_data=0xA1 one cycle after last mem_ready.
REQ-035 Hit after fill: then addr=0x0000010C -> no mem_read; busy=1 one cycle; done=1 read_data=0xA3 in the 2nd cycle after acceptance.
REQ-036 Conflict miss: addr=0x00000504 (same index, tag differs, SETS=64) -> refill from 0x500; later addr=0x104 misses again.
REQ-037 Flush: flush=1 for one cycle during a refill of 0x200 -> request completes with refilled data; next fetch of 0x200 misses and refills.
REQ-038 Reset mid-refill: rst=0 after 2 of 4 mem_ready -> all outputs 0 next cycle; fetch of same address afterwards performs full 4-word refill.
REQ-039 Slow memory: mem_ready held 0 for 5 cycles per word -> mem_addr stable throughout; busy=1 until RESP; exactly one done pulse.
